// File: rtl/updi_line_monitor.sv
// UPDI RX front end: synchronizer, glitch filter, edge pulses and BREAK detection.
// Define UPDI_LINE_BREAK_EN to build the BREAK detector; otherwise break_pulse/in_break are tied low.
module updi_line_monitor #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CLOCKS = 4,
    parameter int BREAK_CLOCKS  = 2400
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic line_o,
    output logic fall_pulse,
    output logic rise_pulse,
    output logic break_pulse,
    output logic in_break
);

    localparam int FLT_W = (FILTER_CLOCKS > 1) ? $clog2(FILTER_CLOCKS) : 1;
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_CLOCKS - 1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [FLT_W-1:0]       flt_cnt_r;
    logic [FLT_W-1:0]       flt_nxt_s;
    logic                   sync_out_s;
    logic                   toggle_s;
    logic                   fall_now_s;
    logic                   rise_now_s;

    // Synchronizer chain; resets to the idle-high level so release creates no edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], rx_in};
        end
    end

    assign sync_out_s = sync_r[SYNC_STAGES-1];

    // Disagreement counter: toggle decision happens on the cycle the count would reach FILTER_CLOCKS.
    always_comb begin
        toggle_s  = 1'b0;
        flt_nxt_s = '0;
        if (sync_out_s != line_o) begin
            if (flt_cnt_r == FLT_LAST) begin
                toggle_s  = 1'b1;
                flt_nxt_s = '0;
            end else begin
                flt_nxt_s = flt_cnt_r + FLT_W'(1);
            end
        end else begin
            flt_nxt_s = '0;
        end
    end

    assign fall_now_s = toggle_s & line_o;
    assign rise_now_s = toggle_s & ~line_o;

    // Filtered line and edge pulses, all updated on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flt_cnt_r  <= '0;
            line_o     <= 1'b1;
            fall_pulse <= 1'b0;
            rise_pulse <= 1'b0;
        end else begin
            flt_cnt_r  <= flt_nxt_s;
            line_o     <= line_o ^ toggle_s;
            fall_pulse <= fall_now_s;
            rise_pulse <= rise_now_s;
        end
    end

`ifdef UPDI_LINE_BREAK_EN
    localparam int LOW_W = $clog2(BREAK_CLOCKS + 1);
    localparam logic [LOW_W-1:0] LOW_LAST = LOW_W'(BREAK_CLOCKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOW   = 2'd1,
        ST_BREAK = 2'd2
    } state_t;

    state_t           state_r;
    logic [LOW_W-1:0] low_cnt_r;

    // Low-time FSM; a rise decided on the threshold cycle takes priority over BREAK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            low_cnt_r   <= '0;
            break_pulse <= 1'b0;
            in_break    <= 1'b0;
        end else begin
            break_pulse <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fall_now_s) begin
                        state_r   <= ST_LOW;
                        low_cnt_r <= LOW_W'(1);
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (rise_now_s) begin
                        state_r   <= ST_IDLE;
                        low_cnt_r <= '0;
                    end else if (low_cnt_r == LOW_LAST) begin
                        state_r     <= ST_BREAK;
                        low_cnt_r   <= low_cnt_r + LOW_W'(1);
                        break_pulse <= 1'b1;
                        in_break    <= 1'b1;
                    end else begin
                        low_cnt_r <= low_cnt_r + LOW_W'(1);
                    end
                end
                ST_BREAK: begin
                    if (rise_now_s) begin
                        state_r   <= ST_IDLE;
                        low_cnt_r <= '0;
                        in_break  <= 1'b0;
                    end else begin
                        state_r   <= ST_BREAK;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    low_cnt_r <= '0;
                    in_break  <= 1'b0;
                end
            endcase
        end
    end
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOW  = 1'b1
    } state_t;

    state_t state_r;

    // Reduced FSM tracking only whether the filtered line is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (fall_now_s) begin
                        state_r <= ST_LOW;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_LOW: begin
                    if (rise_now_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_LOW;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign break_pulse = 1'b0;
    assign in_break    = 1'b0;
`endif

endmodule
